// File: rtl/core_pkg.sv
// Constants and the fetch-state encoding shared by fetch, decode and the
// instruction/data memory models of the RV32IM core.
package core_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS = 1280;

    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_HALT,
        FETCH_FAULT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory port and
// IF/ID outputs. The fetch stage is the master; its environment is the slave.
interface instruction_fetch_if;
    import core_pkg::*;

    // Control semantics (no valid/ready pairs here): stall holds pc and IF/ID
    // for the cycle it is high; redirect_valid is a one-cycle request that
    // wins over stall and over halt; imem_instr must be valid for imem_addr
    // within the same cycle (zero-latency memory).
    logic         stall;
    logic         redirect_valid;
    logic [31:0]  redirect_target;
    logic [31:0]  imem_addr;
    logic [31:0]  imem_instr;
    logic         ifid_valid;
    logic [31:0]  ifid_pc;
    logic [31:0]  ifid_pc_plus4;
    logic [31:0]  ifid_instr;
    logic         halted;
    logic         fault;
    logic [31:0]  fetch_count;
    fetch_state_t fetch_state;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_instr,
        output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr,
        output halted, fault, fetch_count, fetch_state
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_instr,
        input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr,
        input  halted, fault, fetch_count, fetch_state
    );

endinterface

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register with hold and flush. A flush inserts a bubble but
// keeps the last pc fields, so decode always sees a stable pc.
module ifid_reg #(
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_q;
    logic [31:0] instr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= 32'h0;
            pc_plus4_q <= 32'h0;
            instr_q    <= NOP_INSTR;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (!hold_i) begin
            valid_q    <= 1'b1;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_i + 32'd4;
            instr_q    <= instr_i;
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign instr_o    = instr_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the pc, drives the combinational instruction memory and
// fills IF/ID; stops on a zero word (end of program) or an out-of-range pc.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = core_pkg::RESET_PC,
    parameter int unsigned IMEM_WORDS = core_pkg::IMEM_WORDS,
    parameter logic [31:0] NOP_INSTR  = core_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

    logic [31:0]           pc_q;
    logic [31:0]           fetch_count_q;
    core_pkg::fetch_state_t state_q;

    logic fetch_en;
    logic in_range;
    logic end_of_prog;
    logic load;
    logic flush;

    // A fetch slot is spent only when nothing of higher priority claims the
    // edge; a slot that faults or hits the zero word becomes a bubble.
    always_comb begin
        in_range    = pc_q < IMEM_LIMIT;
        end_of_prog = bus.imem_instr == 32'h0;
        fetch_en    = !bus.redirect_valid && (state_q == core_pkg::FETCH_RUN) && !bus.stall;
        load        = fetch_en && in_range && !end_of_prog;
        flush       = bus.redirect_valid || (fetch_en && !load);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'h0;
            state_q       <= core_pkg::FETCH_RUN;
        end else if (bus.redirect_valid) begin
            pc_q    <= bus.redirect_target & 32'hFFFF_FFFC;
            state_q <= core_pkg::FETCH_RUN;
        end else if (fetch_en) begin
            if (!in_range) begin
                state_q <= core_pkg::FETCH_FAULT;
            end else if (end_of_prog) begin
                state_q <= core_pkg::FETCH_HALT;
            end else begin
                pc_q          <= pc_q + 32'd4;
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_i     (!load),
        .flush_i    (flush),
        .pc_i       (pc_q),
        .instr_i    (bus.imem_instr),
        .valid_o    (bus.ifid_valid),
        .pc_o       (bus.ifid_pc),
        .pc_plus4_o (bus.ifid_pc_plus4),
        .instr_o    (bus.ifid_instr)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.halted      = state_q != core_pkg::FETCH_RUN;
    assign bus.fault       = state_q == core_pkg::FETCH_FAULT;
    assign bus.fetch_count = fetch_count_q;
    assign bus.fetch_state = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (full-size memory and a 4-word
// memory) driven by shared stimulus and checked against a per-edge model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if if_a ();
    instruction_fetch_if if_b ();

    instruction_fetch #(.IMEM_WORDS(1280)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    instruction_fetch #(.IMEM_WORDS(4))    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    logic [31:0] mem_a [1280];
    logic [31:0] mem_b [4];

    function automatic logic [31:0] rd(input int id, input logic [31:0] addr);
        if (id == 0) return (addr < 32'd5120) ? mem_a[addr[12:2]] : 32'hFFFF_FFFF;
        return (addr < 32'd16) ? mem_b[addr[3:2]] : 32'hFFFF_FFFF;
    endfunction

    assign if_a.imem_instr = rd(0, if_a.imem_addr);
    assign if_b.imem_instr = rd(1, if_b.imem_addr);

    // Reference model: architectural view of the fetch stage per instance.
    logic [31:0] m_pc [2];
    logic [31:0] m_ipc [2];
    logic [31:0] m_ip4 [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_cnt [2];
    logic        m_valid [2];
    logic        m_halt [2];
    logic        m_fault [2];
    logic [31:0] m_limit [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int d, input logic r, input logic st,
                              input logic rv, input logic [31:0] tgt);
        logic [31:0] w;
        w = rd(d, m_pc[d]);
        if (!r) begin
            m_pc[d] = 32'h0; m_valid[d] = 1'b0; m_ipc[d] = 32'h0; m_ip4[d] = 32'h0;
            m_instr[d] = NOP; m_halt[d] = 1'b0; m_fault[d] = 1'b0; m_cnt[d] = 32'h0;
        end else if (rv) begin
            m_pc[d] = {tgt[31:2], 2'b00};
            m_valid[d] = 1'b0; m_instr[d] = NOP;
            m_halt[d] = 1'b0; m_fault[d] = 1'b0;
        end else if (m_halt[d] || st) begin
            // everything holds
        end else if (m_pc[d] >= m_limit[d]) begin
            m_fault[d] = 1'b1; m_halt[d] = 1'b1; m_valid[d] = 1'b0; m_instr[d] = NOP;
        end else if (w == 32'h0) begin
            m_halt[d] = 1'b1; m_valid[d] = 1'b0; m_instr[d] = NOP;
        end else begin
            m_valid[d] = 1'b1; m_ipc[d] = m_pc[d]; m_ip4[d] = m_pc[d] + 32'd4;
            m_instr[d] = w; m_pc[d] = m_pc[d] + 32'd4; m_cnt[d] = m_cnt[d] + 32'd1;
        end
    endtask

    task automatic compare_all();
        check("a_addr",  if_a.imem_addr,     m_pc[0]);
        check("a_valid", if_a.ifid_valid,    m_valid[0]);
        check("a_ifpc",  if_a.ifid_pc,       m_ipc[0]);
        check("a_ifp4",  if_a.ifid_pc_plus4, m_ip4[0]);
        check("a_instr", if_a.ifid_instr,    m_instr[0]);
        check("a_halt",  if_a.halted,        m_halt[0]);
        check("a_fault", if_a.fault,         m_fault[0]);
        check("a_count", if_a.fetch_count,   m_cnt[0]);
        check("b_addr",  if_b.imem_addr,     m_pc[1]);
        check("b_valid", if_b.ifid_valid,    m_valid[1]);
        check("b_ifpc",  if_b.ifid_pc,       m_ipc[1]);
        check("b_ifp4",  if_b.ifid_pc_plus4, m_ip4[1]);
        check("b_instr", if_b.ifid_instr,    m_instr[1]);
        check("b_halt",  if_b.halted,        m_halt[1]);
        check("b_fault", if_b.fault,         m_fault[1]);
        check("b_count", if_b.fetch_count,   m_cnt[1]);
    endtask

    // Drive one edge's inputs, advance the model, then sample after the edge.
    task automatic cycle(input logic r, input logic st, input logic rv, input logic [31:0] tgt);
        rst_n = r;
        if_a.stall = st; if_a.redirect_valid = rv; if_a.redirect_target = tgt;
        if_b.stall = st; if_b.redirect_valid = rv; if_b.redirect_target = tgt;
        #1;
        for (int d = 0; d < 2; d++) model_step(d, r, st, rv, tgt);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [31:0] tgt;
        logic        r, st, rv;

        m_limit[0] = 32'd5120;
        m_limit[1] = 32'd16;
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = 32'h0; m_ipc[d] = 32'h0; m_ip4[d] = 32'h0; m_instr[d] = NOP;
            m_cnt[d] = 32'h0; m_valid[d] = 1'b0; m_halt[d] = 1'b0; m_fault[d] = 1'b0;
        end
        mem_a[0] = 32'h0000_2083;
        for (int i = 1; i < 12; i++) mem_a[i] = $urandom | 32'h1;
        mem_a[12] = 32'h0;
        for (int i = 13; i < 1280; i++) mem_a[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
        for (int i = 0; i < 4; i++) mem_b[i] = $urandom | 32'h1;
        if_a.stall = 1'b0; if_a.redirect_valid = 1'b0; if_a.redirect_target = 32'h0;
        if_b.stall = 1'b0; if_b.redirect_valid = 1'b0; if_b.redirect_target = 32'h0;

        // Reset state.
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_addr", if_a.imem_addr, 32'h0);
        check("rst_instr", if_a.ifid_instr, NOP);

        // Straight-line program: halts on the zero word at 0x30; small memory faults at 0x10.
        repeat (13) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("eop_halt", if_a.halted, 32'h1);
        check("eop_pc", if_a.imem_addr, 32'h30);
        check("eop_count", if_a.fetch_count, 32'd12);
        check("flt_fault", if_b.fault, 32'h1);
        check("flt_pc", if_b.imem_addr, 32'h10);
        check("flt_ifpc", if_b.ifid_pc, 32'h0C);

        // Restart from halt, then stall with 0x08 in IF/ID.
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        check("restart_halt", if_a.halted, 32'h0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_stall_ifpc", if_a.ifid_pc, 32'h08);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("stall_ifpc", if_a.ifid_pc, 32'h08);
        check("stall_pc", if_a.imem_addr, 32'h0C);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("post_stall_ifpc", if_a.ifid_pc, 32'h0C);

        // Redirect with low target bits set, overriding a stall at pc 0x10.
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0013);
        check("redir_pc", if_a.imem_addr, 32'h10);
        check("redir_valid", if_a.ifid_valid, 32'h0);
        check("redir_instr", if_a.ifid_instr, NOP);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("redir_ifpc", if_a.ifid_pc, 32'h10);
        check("redir_count", if_a.fetch_count, 32'd17);

        // Reset mid-run at pc 0x20 with 8 fetches done.
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("mid_pc", if_a.imem_addr, 32'h20);
        check("mid_count", if_a.fetch_count, 32'd8);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("mid_rst_addr", if_a.imem_addr, 32'h0);
        check("mid_rst_count", if_a.fetch_count, 32'h0);

        // Randomized mix of stalls, redirects (including range edges) and resets.
        repeat (800) begin
            r  = ($urandom_range(0, 99) != 0);
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 6))
                0:       tgt = 32'h0;
                1:       tgt = 32'($urandom_range(0, 64));
                2:       tgt = 32'h13F0 | 32'($urandom_range(0, 3));
                3:       tgt = 32'h13FC;
                4:       tgt = 32'h1400 | 32'($urandom_range(0, 3));
                5:       tgt = 32'hFFFF_FFFC;
                default: tgt = $urandom;
            endcase
            cycle(r, st, rv, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
